// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types, default timing constants and small helpers for the 4x4 keypad
// scanner.
//   state_t     : scanner FSM states
//   key_code_t  : 4-bit key code, row*4 + col
//   DEF_*_TIME  : default timing in clock cycles (50 MHz reference clock)
// Optional feature macro used by the scanner: KEYPAD_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    typedef logic [3:0] key_code_t;

    localparam int unsigned DEF_SCAN_TIME     = 50_000;      // 1 ms
    localparam int unsigned DEF_DEBOUNCE_TIME = 1_000_000;   // 20 ms
    localparam int unsigned DEF_REPEAT_TIME   = 25_000_000;  // 500 ms

    // Index of the lowest-numbered row that is pulled low (rows are active-low).
    // Returns 0 when no row is low; callers only use it when some row is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/row_sync.sv
// -----------------------------------------------------------------------------
// row_sync
// Two-flop synchronizer for the four asynchronous, active-low keypad rows.
// Both stages reset to 1 so an idle (pulled-up) keypad is seen during and
// right after reset.
//   clk  : clock
//   rst  : synchronous active-high reset
//   rows : raw keypad rows (asynchronous)
//   srow : synchronized rows
// -----------------------------------------------------------------------------
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] srow
);

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 4'hF;
            sync_reg <= 4'hF;
        end else begin
            meta_reg <= rows;
            sync_reg <= meta_reg;
        end
    end

    assign srow = sync_reg;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
// 4x4 matrix keypad scanner with press/release debounce.
// One column at a time is driven low for SCAN_TIME cycles; if any synchronized
// row is low at the end of that window, the column and lowest low row are
// latched and only that key is watched until it has been released for
// DEBOUNCE_TIME consecutive cycles.
//
// Parameters:
//   SCAN_TIME     : cycles each column is driven before rows are sampled
//   DEBOUNCE_TIME : consecutive stable cycles for press and for release
//   REPEAT_TIME   : auto-repeat period (only with KEYPAD_AUTOREPEAT_EN)
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   row_in    : keypad rows, asynchronous, active-low
//   col_out   : column drive, active-low, one bit low at a time
//   key_code  : last accepted key, row*4 + col, held between events
//   key_valid : one-cycle pulse per accepted key event
//   key_held  : high while the accepted key is still considered pressed
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every
// REPEAT_TIME cycles while a key stays in PRESSED.
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_TIME     = keypad_pkg::DEF_SCAN_TIME,
    parameter int unsigned DEBOUNCE_TIME = keypad_pkg::DEF_DEBOUNCE_TIME,
    parameter int unsigned REPEAT_TIME   = keypad_pkg::DEF_REPEAT_TIME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_pkg::*;

    localparam logic [31:0] SCAN_LAST = 32'(SCAN_TIME - 1);
    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_TIME - 1);

    logic [3:0]  srow;
    state_t      state_reg;
    logic [1:0]  col_reg;
    logic [1:0]  row_reg;
    logic [31:0] cnt_reg;
    key_code_t   key_code_reg;
    logic        key_valid_reg;
    logic        key_held_reg;
    logic        row_bit;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [31:0] REP_LAST = 32'(REPEAT_TIME - 1);
    logic [31:0] rep_reg;
`endif

    row_sync u_row_sync (
        .clk  (clk),
        .rst  (rst),
        .rows (row_in),
        .srow (srow)
    );

    // Only the latched row of the latched column is watched once a key is found.
    assign row_bit = srow[row_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            row_reg       <= 2'd0;
            cnt_reg       <= 32'd0;
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_reg       <= 32'd0;
`endif
        end else begin
            key_valid_reg <= 1'b0;
            case (state_reg)
                SCAN: begin
                    if (cnt_reg == SCAN_LAST) begin
                        cnt_reg <= 32'd0;
                        if (srow != 4'hF) begin
                            row_reg   <= lowest_low_row(srow);
                            state_reg <= DEBOUNCE;
                        end else begin
                            col_reg <= col_reg + 2'd1;
                        end
                    end else begin
                        cnt_reg <= sat_inc(cnt_reg);
                    end
                end

                DEBOUNCE: begin
                    if (!row_bit) begin
                        if (cnt_reg == DEB_LAST) begin
                            state_reg     <= PRESSED;
                            cnt_reg       <= 32'd0;
                            key_code_reg  <= {row_reg, col_reg};
                            key_valid_reg <= 1'b1;
                            key_held_reg  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_reg       <= 32'd0;
`endif
                        end else begin
                            cnt_reg <= sat_inc(cnt_reg);
                        end
                    end else begin
                        // Bounce: rescan the same column from the start.
                        state_reg <= SCAN;
                        cnt_reg   <= 32'd0;
                    end
                end

                PRESSED: begin
                    if (row_bit) begin
                        state_reg <= RELEASE_WAIT;
                        cnt_reg   <= 32'd0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_reg == REP_LAST) begin
                        key_valid_reg <= 1'b1;
                        rep_reg       <= 32'd0;
                    end else begin
                        rep_reg <= sat_inc(rep_reg);
                    end
`endif
                end

                RELEASE_WAIT: begin
                    if (row_bit) begin
                        if (cnt_reg == DEB_LAST) begin
                            state_reg    <= SCAN;
                            cnt_reg      <= 32'd0;
                            key_held_reg <= 1'b0;
                            col_reg      <= col_reg + 2'd1;
                        end else begin
                            cnt_reg <= sat_inc(cnt_reg);
                        end
                    end else begin
                        // Any low cycle restarts the release window.
                        cnt_reg <= 32'd0;
                    end
                end

                default: begin
                    state_reg <= SCAN;
                    cnt_reg   <= 32'd0;
                end
            endcase
        end
    end

    // col_reg is registered, so the decoded drive changes only on clock edges.
    assign col_out   = ~(4'b0001 << col_reg);
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Scoreboard bench for keypad_scan_ctrl with SCAN_TIME=4, DEBOUNCE_TIME=8,
// REPEAT_TIME=16. A keypad matrix model pulls a row low only while the column
// of a pressed key is driven. Expected key events (code, cycle) are queued by
// the stimulus; a monitor pops and compares on every key_valid pulse.
// Cycle numbering: period 0 starts at the negedge where rst is released.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] key_mask;   // bit r*4+c set = key at row r, column c pressed
    int          cyc;
    int          checks;
    int          failures;
    logic        kv_prev;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    keypad_scan_ctrl #(
        .SCAN_TIME     (4),
        .DEBOUNCE_TIME (8),
        .REPEAT_TIME   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r * 4 + c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (key_valid) begin
            check("key_valid_not_back_to_back", int'(kv_prev), 0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_key_valid at cycle %0d: got code %0d expected no event",
                         cyc, key_code);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("event_code", int'(key_code), int'(e.code));
                check("event_cycle", cyc, e.cyc);
                $display("event code=%0d cycle=%0d (expected code=%0d cycle=%0d)",
                         key_code, cyc, e.code, e.cyc);
            end
        end
        kv_prev = key_valid;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_out"},   int'(col_out),   4'b1110);
        check({tag, "_key_code"},  int'(key_code),  0);
        check({tag, "_key_valid"}, int'(key_valid), 0);
        check({tag, "_key_held"},  int'(key_held),  0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic expect_key(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        logic [3:0] exp_col;
        rst      = 1'b1;
        key_mask = 16'h0;
        checks   = 0;
        failures = 0;
        kv_prev  = 1'b0;

        // Idle scan: each column low for four cycles, wrapping after column 3.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            wait_cyc(k);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("idle_col_out", int'(col_out), int'(exp_col));
        end
        check_drained("idle_no_events");

        // Row 2 / column 1 held: accept at cycle 16 with code 9.
        key_mask = 16'h0200;
        do_reset();
        expect_key(4'd9, 16);
`ifdef KEYPAD_AUTOREPEAT_EN
        expect_key(4'd9, 32);
        expect_key(4'd9, 48);
`endif
        wait_cyc(20);
        check("press_key_held", int'(key_held), 1);
        check("press_col_out", int'(col_out), 4'b1101);
        check("press_key_code", int'(key_code), 9);
        wait_cyc(56);
        check("hold_key_held", int'(key_held), 1);
        check("hold_col_out", int'(col_out), 4'b1101);
        check_drained("press_events_done");
        key_mask = 16'h0;

        // Three-cycle bounce on column 1: rejected, column 1 rescanned.
        do_reset();
        wait_cyc(5);
        key_mask = 16'h0200;
        wait_cyc(8);
        key_mask = 16'h0;
        wait_cyc(12);
        check("bounce_col_same", int'(col_out), 4'b1101);
        check("bounce_key_held", int'(key_held), 0);
        wait_cyc(14);
        check("bounce_col_late", int'(col_out), 4'b1101);
        wait_cyc(15);
        check("bounce_col_next", int'(col_out), 4'b1011);
        check_drained("bounce_no_events");

        // Release with a two-cycle glitch: held until cycle 36, clear at 37.
        key_mask = 16'h0200;
        do_reset();
        expect_key(4'd9, 16);
        wait_cyc(20);
        key_mask = 16'h0;
        wait_cyc(25);
        key_mask = 16'h0200;
        wait_cyc(27);
        key_mask = 16'h0;
        wait_cyc(30);
        check("glitch_held_30", int'(key_held), 1);
        wait_cyc(36);
        check("glitch_held_36", int'(key_held), 1);
        wait_cyc(37);
        check("glitch_released_37", int'(key_held), 0);
        check("glitch_col_adv", int'(col_out), 4'b1011);
        check_drained("glitch_events_done");

        // Reset during DEBOUNCE on column 2 (row 0): aborted, no event.
        key_mask = 16'h0004;
        wait_cyc(44);
        check("debounce_col_held", int'(col_out), 4'b1011);
        check("debounce_code_prev", int'(key_code), 9);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        key_mask = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(10);
        check_drained("mid_reset_no_events");

        // Rows 1 and 3 on column 0: lowest row wins (code 4); other keys ignored.
        key_mask = 16'h1010;
        do_reset();
        expect_key(4'd4, 12);
        wait_cyc(16);
        key_mask = key_mask | 16'h0001;
        wait_cyc(20);
        key_mask = key_mask & ~16'h0010;
        wait_cyc(30);
        check("multi_held_30", int'(key_held), 1);
        wait_cyc(31);
        check("multi_released_31", int'(key_held), 0);
        check("multi_col_adv", int'(col_out), 4'b1101);
        check("multi_code_kept", int'(key_code), 4);
        key_mask = 16'h0;
        wait_cyc(40);
        check_drained("multi_events_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
